// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {instr, pc, npc}
// with valid/ready on both sides, synchronous flush and sticky overflow flag.
module fetch_decode_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH  = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [INSTR_WIDTH-1:0]   in_instr,
  input  logic [ADDR_WIDTH-1:0]    in_pc,
  input  logic [ADDR_WIDTH-1:0]    in_npc,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [INSTR_WIDTH-1:0]   out_instr,
  output logic [ADDR_WIDTH-1:0]    out_pc,
  output logic [ADDR_WIDTH-1:0]    out_npc,
  output logic                     out_halt,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];
  logic [ADDR_WIDTH-1:0]  npc_mem   [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             ovf_q,    ovf_d;
  logic             push, pop;

  // Handshake qualification; flush kills both sides, reset blocks storage writes
  always_comb begin
    in_ready  = (count_q != CNT_W'(DEPTH));
    out_valid = (count_q != '0);
    push      = in_valid & in_ready & ~flush & reset;
    pop       = out_valid & out_ready & ~flush;
  end

  // Head entry read straight from storage; halt marker is an all-zero instruction
  always_comb begin
    out_instr = instr_mem[rd_ptr_q];
    out_pc    = pc_mem[rd_ptr_q];
    out_npc   = npc_mem[rd_ptr_q];
    out_halt  = out_valid & (out_instr == '0);
    count     = count_q;
    ovf_err   = ovf_q;
  end

  // Next-state for pointers, occupancy and overflow flag
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (in_valid & ~in_ready & ~flush);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  // Control state; storage itself is deliberately left uncleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage write on accepted push
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= in_instr;
      pc_mem[wr_ptr_q]    <= in_pc;
      npc_mem[wr_ptr_q]   <= in_npc;
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue: vector table plus a few hand sequences.
module tb_fetch_decode_queue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic [63:0] in_npc;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [63:0] out_npc;
  logic        out_halt;
  logic        out_ready;
  logic        flush;
  logic [2:0]  count;
  logic        ovf_err;

  int checks;
  int errors;

  fetch_decode_queue #(.DEPTH(4), .INSTR_WIDTH(32), .ADDR_WIDTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_npc    (in_npc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_npc   (out_npc),
    .out_halt  (out_halt),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count),
    .ovf_err   (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        ro;
    logic        fl;
    int          cnt;
    logic        ov;
    logic [63:0] epc;
    logic [31:0] einstr;
    logic        halt;
    logic        ovf;
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] ins(input logic [63:0] pc);
    return 32'hA000_0000 | 32'(pc[15:0]);
  endfunction

  task automatic add(input logic rst, input logic iv, input logic [31:0] instr,
                     input logic [63:0] pc, input logic ro, input logic fl,
                     input int cnt, input logic ov, input logic [63:0] epc,
                     input logic [31:0] einstr, input logic halt, input logic ovf);
    vec_t v;
    v.rst = rst; v.iv = iv; v.instr = instr; v.pc = pc; v.ro = ro; v.fl = fl;
    v.cnt = cnt; v.ov = ov; v.epc = epc; v.einstr = einstr; v.halt = halt; v.ovf = ovf;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=0x%0h expected=0x%0h", name, idx, act, exp);
    end
  endtask

  // Push/pop shorthands: P = push with ro=0, X = pop only, B = push+pop
  task automatic P(input logic [63:0] pc, input int cnt, input logic [63:0] hpc, input logic ovf);
    add(1, 1, ins(pc), pc, 0, 0, cnt, 1, hpc, ins(hpc), 0, ovf);
  endtask
  task automatic X(input int cnt, input logic [63:0] hpc, input logic ovf);
    add(1, 0, 32'h0, 64'h0, 1, 0, cnt, cnt != 0, hpc, (cnt != 0) ? ins(hpc) : 32'h0, 0, ovf);
  endtask
  task automatic B(input logic [63:0] pc, input int cnt, input logic [63:0] hpc, input logic ovf);
    add(1, 1, ins(pc), pc, 1, 0, cnt, 1, hpc, ins(hpc), 0, ovf);
  endtask

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;
    reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_npc = '0;
    out_ready = 1'b0; flush = 1'b0;

    // Reset held 3 cycles with in_valid asserted
    for (int i = 0; i < 3; i++) add(0, 1, 32'hDEAD_BEEF, 64'h9000, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 32'h0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Single push then pop
    add(1, 1, 32'h0050_0093, 64'h1000, 0, 0, 1, 1, 64'h1000, 32'h0050_0093, 0, 0);
    X(0, 0, 0);
    // Fill to full, overflow attempt, pop 2, push 2 across the wrap, drain 2
    P(64'h1000, 1, 64'h1000, 0);
    P(64'h1004, 2, 64'h1000, 0);
    P(64'h1008, 3, 64'h1000, 0);
    P(64'h100C, 4, 64'h1000, 0);
    P(64'h1010, 4, 64'h1000, 1);
    X(3, 64'h1004, 1);
    X(2, 64'h1008, 1);
    P(64'h1010, 3, 64'h1008, 1);
    P(64'h1014, 4, 64'h1008, 1);
    X(3, 64'h100C, 1);
    X(2, 64'h1010, 1);
    // Simultaneous push+pop at count 2
    B(64'h1018, 2, 64'h1014, 1);
    B(64'h101C, 2, 64'h1018, 1);
    X(1, 64'h101C, 1);
    X(0, 0, 1);
    // Full queue refuses push even when a pop happens the same cycle
    P(64'h3000, 1, 64'h3000, 1);
    P(64'h3004, 2, 64'h3000, 1);
    P(64'h3008, 3, 64'h3000, 1);
    P(64'h300C, 4, 64'h3000, 1);
    B(64'h3010, 3, 64'h3004, 1);
    X(2, 64'h3008, 1);
    X(1, 64'h300C, 1);
    X(0, 0, 1);
    // Flush at count 3 with a push pending
    P(64'h4000, 1, 64'h4000, 1);
    P(64'h4004, 2, 64'h4000, 1);
    P(64'h4008, 3, 64'h4000, 1);
    add(1, 1, ins(64'h2000), 64'h2000, 1, 1, 0, 0, 0, 0, 0, 1);
    add(1, 0, 32'h0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 1);
    P(64'h5000, 1, 64'h5000, 1);
    X(0, 0, 1);
    // Halt marker flagged only while at the head
    add(1, 1, 32'h0, 64'h6000, 0, 0, 1, 1, 64'h6000, 32'h0, 1, 1);
    add(1, 1, ins(64'h6004), 64'h6004, 0, 0, 2, 1, 64'h6000, 32'h0, 1, 1);
    X(1, 64'h6004, 1);
    X(0, 0, 1);
    // Reset mid-operation clears entries and ovf
    P(64'h7000, 1, 64'h7000, 1);
    P(64'h7004, 2, 64'h7000, 1);
    add(0, 0, 32'h0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 32'h0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Flush while full with in_valid does not set ovf
    P(64'h8000, 1, 64'h8000, 0);
    P(64'h8004, 2, 64'h8000, 0);
    P(64'h8008, 3, 64'h8000, 0);
    P(64'h800C, 4, 64'h8000, 0);
    add(1, 1, ins(64'h8010), 64'h8010, 0, 1, 0, 0, 0, 0, 0, 0);
    P(64'h8020, 1, 64'h8020, 0);
    X(0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      @(negedge clk);
      reset = v.rst; in_valid = v.iv; in_instr = v.instr; in_pc = v.pc;
      in_npc = v.pc + 64'd4; out_ready = v.ro; flush = v.fl;
      @(posedge clk);
      #1;
      chk("count", i, 64'(count), 64'(v.cnt));
      chk("out_valid", i, 64'(out_valid), 64'(v.ov));
      chk("in_ready", i, 64'(in_ready), 64'(v.cnt != 4));
      chk("ovf_err", i, 64'(ovf_err), 64'(v.ovf));
      chk("out_halt", i, 64'(out_halt), 64'(v.halt));
      if (v.ov) begin
        chk("out_pc", i, out_pc, v.epc);
        chk("out_npc", i, out_npc, v.epc + 64'd4);
        chk("out_instr", i, 64'(out_instr), 64'(v.einstr));
      end
    end

    // No same-cycle bypass: a push into an empty queue is invisible before the edge
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; in_instr = 32'h1234_5678; in_pc = 64'hA000;
    in_npc = 64'hA004; out_ready = 1'b0; flush = 1'b0;
    #1;
    chk("bypass_valid", -1, 64'(out_valid), 64'd0);
    chk("bypass_count", -1, 64'(count), 64'd0);
    @(posedge clk);
    #1;
    chk("latency_valid", -1, 64'(out_valid), 64'd1);
    chk("latency_pc", -1, out_pc, 64'hA000);

    // Asynchronous reset between edges empties the queue immediately
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_count", -1, 64'(count), 64'd0);
    chk("async_valid", -1, 64'(out_valid), 64'd0);
    chk("async_ready", -1, 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_count", -1, 64'(count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
